csa_pipe_adder: RTL

//  Parametrised, pipelined carry-select adder/subtractor; successor to the fixed 16-bit, 4-bit-block CSA.
//  - Operands split into BLK_W-bit blocks; each block precomputes cin=0 and cin=1 results and muxes on the incoming carry.
//  - Blocks are grouped BLKS_PER_STG per pipeline stage, with valid/ready handshakes on both sides.
//  - Sits between operand-issue logic and a result consumer in the datapath.

---
 rtl/csa_pipe_adder_if.sv | 27 ++
 rtl/csa_pipe_adder.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/csa_pipe_adder_if.sv
// Operand/result stream bundle for the pipelined carry-select adder.
// master drives operands and consumes results; slave is the adder.
interface csa_pipe_adder_if #(
    parameter int unsigned WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_cin;
    logic             in_sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_cout;
    logic             out_ovf;

    modport master (
        output in_valid, in_a, in_b, in_cin, in_sub, out_ready,
        input  in_ready, out_valid, out_sum, out_cout, out_ovf
    );

    modport slave (
        input  in_valid, in_a, in_b, in_cin, in_sub, out_ready,
        output in_ready, out_valid, out_sum, out_cout, out_ovf
    );
endinterface

// File: rtl/csa_pipe_adder.sv
// Parametrised pipelined carry-select adder/subtractor with valid/ready on both sides.
// Each stage resolves BLKS_PER_STG blocks from the carry registered by the previous stage.
module csa_pipe_adder #(
    parameter int unsigned WIDTH        = 16,
    parameter int unsigned BLK_W        = 4,
    parameter int unsigned BLKS_PER_STG = 1
) (
    input  logic              clk,
    input  logic              rst,
    csa_pipe_adder_if.slave   bus
);
    localparam int unsigned NUM_BLK = WIDTH / BLK_W;
    localparam int unsigned NUM_STG = NUM_BLK / BLKS_PER_STG;
    localparam int unsigned LAST    = NUM_STG - 1;

    generate
        if (BLK_W == 0 || BLKS_PER_STG == 0 || (WIDTH % BLK_W) != 0 ||
            NUM_BLK == 0 || (NUM_BLK % BLKS_PER_STG) != 0) begin : g_bad_param
            $error("csa_pipe_adder: illegal WIDTH/BLK_W/BLKS_PER_STG combination");
        end
    endgenerate

    // Per-stage registers; a/b hold B already inverted for subtract
    logic [WIDTH-1:0]   a_q [NUM_STG];
    logic [WIDTH-1:0]   b_q [NUM_STG];
    logic [WIDTH-1:0]   s_q [NUM_STG];
    logic [NUM_STG-1:0] c_q;
    logic [NUM_STG-1:0] cm_q;
    logic [NUM_STG-1:0] ovf_q;
    logic [NUM_STG-1:0] v_q;

    logic [WIDTH-1:0]   a_d [NUM_STG];
    logic [WIDTH-1:0]   b_d [NUM_STG];
    logic [WIDTH-1:0]   s_d [NUM_STG];
    logic [NUM_STG-1:0] c_d;
    logic [NUM_STG-1:0] cm_d;
    logic [NUM_STG-1:0] ovf_d;
    logic [NUM_STG-1:0] adv;
    logic [NUM_STG-1:0] ld;

    logic               nxt;
    logic               carry;
    logic               cm;
    logic               src_v;
    logic [WIDTH-1:0]   a_src;
    logic [WIDTH-1:0]   b_src;
    logic [WIDTH-1:0]   s_src;
    logic [BLK_W:0]     r0;
    logic [BLK_W:0]     r1;
    int unsigned        lo;
    int unsigned        p;

    always_comb begin
        adv   = '0;
        ld    = '0;
        c_d   = '0;
        cm_d  = '0;
        ovf_d = '0;
        nxt   = 1'b0;
        carry = 1'b0;
        cm    = 1'b0;
        src_v = 1'b0;
        a_src = '0;
        b_src = '0;
        s_src = '0;
        r0    = '0;
        r1    = '0;
        lo    = 0;
        p     = 0;
        for (int k = 0; k < NUM_STG; k++) begin
            a_d[k] = '0;
            b_d[k] = '0;
            s_d[k] = '0;
        end

        // A stage advances when empty or when its successor takes its beat
        nxt = bus.out_ready;
        for (int k = NUM_STG - 1; k >= 0; k--) begin
            nxt    = !v_q[k] || nxt;
            adv[k] = nxt;
        end

        for (int k = 0; k < NUM_STG; k++) begin
            p = (k == 0) ? 0 : 32'(k - 1);
            if (k == 0) begin
                a_src = bus.in_a;
                b_src = bus.in_sub ? ~bus.in_b : bus.in_b;
                s_src = '0;
                carry = bus.in_sub | bus.in_cin;
                cm    = 1'b0;
                src_v = bus.in_valid;
            end else begin
                a_src = a_q[p];
                b_src = b_q[p];
                s_src = s_q[p];
                carry = c_q[p];
                cm    = cm_q[p];
                src_v = v_q[p];
            end
            ld[k] = adv[k] && src_v;

            // Both carry-in candidates are formed, then the incoming carry picks one
            for (int j = 0; j < BLKS_PER_STG; j++) begin
                lo = (32'(k) * BLKS_PER_STG + 32'(j)) * BLK_W;
                r0 = {1'b0, a_src[lo +: BLK_W]} + {1'b0, b_src[lo +: BLK_W]};
                r1 = r0 + {{BLK_W{1'b0}}, 1'b1};
                if (lo + BLK_W == WIDTH) begin
                    cm = a_src[WIDTH-1] ^ b_src[WIDTH-1] ^
                         (carry ? r1[BLK_W-1] : r0[BLK_W-1]);
                end
                {carry, s_src[lo +: BLK_W]} = carry ? r1 : r0;
            end

            a_d[k]   = a_src;
            b_d[k]   = b_src;
            s_d[k]   = s_src;
            c_d[k]   = carry;
            cm_d[k]  = cm;
            ovf_d[k] = cm ^ carry;
        end
    end

    // Data registers only load on a real beat so the result holds when idle
    always_ff @(posedge clk) begin
        if (rst) begin
            v_q   <= '0;
            c_q   <= '0;
            cm_q  <= '0;
            ovf_q <= '0;
            for (int k = 0; k < NUM_STG; k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
                s_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NUM_STG; k++) begin
                if (adv[k]) begin
                    v_q[k] <= ld[k];
                end
                if (ld[k]) begin
                    a_q[k]   <= a_d[k];
                    b_q[k]   <= b_d[k];
                    s_q[k]   <= s_d[k];
                    c_q[k]   <= c_d[k];
                    cm_q[k]  <= cm_d[k];
                    ovf_q[k] <= ovf_d[k];
                end
            end
        end
    end

    assign bus.in_ready  = adv[0];
    assign bus.out_valid = v_q[LAST];
    assign bus.out_sum   = s_q[LAST];
    assign bus.out_cout  = c_q[LAST];
    assign bus.out_ovf   = ovf_q[LAST];
endmodule
